// File: rtl/drlp_sld_pkg.sv
// Shared types and config helpers for the drlp sliding-window block.
package drlp_sld_pkg;

  localparam int CFG_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } sld_state_t;

  // Kernel dimensions are forced into 1..max_val so a bad config never
  // produces an empty or oversize window.
  function automatic int unsigned clamp_dim(input int unsigned val, input int unsigned max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

  function automatic int unsigned clamp_kw(input int unsigned val, input int unsigned col_num);
    return clamp_dim(val, col_num);
  endfunction

  function automatic int unsigned clamp_kh(input int unsigned val, input int unsigned row_num);
    return clamp_dim(val, row_num);
  endfunction

  function automatic int unsigned clamp_stride(input int unsigned val);
    return (val == 0) ? 1 : val;
  endfunction

endpackage

// File: rtl/drlp_sld_win_ctrl.sv
// Sequencing for the sliding window: config latch, fill/stride counters,
// column-ready and window-valid handshakes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no config yet, columns refused
// ST_FILL | first kw columns being collected, o_fill counting up
// ST_RUN  | window full, a new window every stride accepted columns
module drlp_sld_win_ctrl
  import drlp_sld_pkg::*;
#(
  parameter int ROW_NUM = 6,
  parameter int COL_NUM = 6,
  parameter int CFG_W   = CFG_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_load,
  input  logic [CFG_W-1:0] i_cfg_kw,
  input  logic [CFG_W-1:0] i_cfg_kh,
  input  logic [CFG_W-1:0] i_cfg_stride,
  input  logic             i_col_valid,
  input  logic             i_win_ready,
  output logic             o_col_ready,
  output logic             o_accept,
  output logic             o_win_valid,
  output logic [CFG_W-1:0] o_fill,
  output logic [CFG_W-1:0] o_kw,
  output logic [CFG_W-1:0] o_kh
);

  sld_state_t       state_q, state_d;
  logic [CFG_W-1:0] fill_q, fill_d, fill_inc;
  logic [CFG_W-1:0] gap_q, gap_d, gap_inc;
  logic [CFG_W-1:0] kw_q, kh_q, stride_q;
  logic             win_valid_q, win_valid_d;
  logic             set_valid;

  assign o_col_ready = (state_q != ST_IDLE) & ~i_cfg_load & (~win_valid_q | i_win_ready);
  assign o_accept    = i_col_valid & o_col_ready;
  assign o_win_valid = win_valid_q;
  assign o_fill      = fill_q;
  assign o_kw        = kw_q;
  assign o_kh        = kh_q;
  assign fill_inc    = fill_q + CFG_W'(1);
  assign gap_inc     = gap_q + CFG_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      fill_q      <= '0;
      gap_q       <= '0;
      win_valid_q <= 1'b0;
      kw_q        <= CFG_W'(1);
      kh_q        <= CFG_W'(1);
      stride_q    <= CFG_W'(1);
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      gap_q       <= gap_d;
      win_valid_q <= win_valid_d;
      if (i_cfg_load) begin
        kw_q     <= CFG_W'(clamp_kw(int'(unsigned'(i_cfg_kw)), COL_NUM));
        kh_q     <= CFG_W'(clamp_kh(int'(unsigned'(i_cfg_kh)), ROW_NUM));
        stride_q <= CFG_W'(clamp_stride(int'(unsigned'(i_cfg_stride))));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    set_valid = 1'b0;
    if (i_cfg_load) begin
      state_d = ST_FILL;
      fill_d  = '0;
      gap_d   = '0;
    end else if (o_accept) begin
      case (state_q)
        ST_FILL: begin
          fill_d = fill_inc;
          if (fill_inc == kw_q) begin
            set_valid = 1'b1;
            state_d   = ST_RUN;
            gap_d     = '0;
          end
        end
        ST_RUN: begin
          if (gap_inc == stride_q) begin
            set_valid = 1'b1;
            gap_d     = '0;
          end else begin
            gap_d = gap_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // A fresh window on the same edge as a handshake keeps valid asserted.
  always_comb begin
    win_valid_d = win_valid_q;
    if (i_cfg_load)                      win_valid_d = 1'b0;
    else if (set_valid)                  win_valid_d = 1'b1;
    else if (win_valid_q && i_win_ready) win_valid_d = 1'b0;
  end

endmodule

// File: rtl/drlp_sld_win.sv
// Sliding-window register file: shifts accepted columns into a ROW_NUM x COL_NUM
// window. Optional zero-padding input enabled by DRLP_SLD_WIN_PAD_EN.
module drlp_sld_win
  import drlp_sld_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 6,
  parameter int COL_NUM    = 6,
  parameter int CFG_W      = CFG_W_DEF
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_cfg_load,
  input  logic [CFG_W-1:0]                      i_cfg_kw,
  input  logic [CFG_W-1:0]                      i_cfg_kh,
  input  logic [CFG_W-1:0]                      i_cfg_stride,
  input  logic [DATA_WIDTH*ROW_NUM-1:0]         i_col_data,
  input  logic                                  i_col_valid,
`ifdef DRLP_SLD_WIN_PAD_EN
  input  logic                                  i_col_pad,
`endif
  output logic                                  o_col_ready,
  output logic [DATA_WIDTH*ROW_NUM*COL_NUM-1:0] o_win,
  output logic                                  o_win_valid,
  input  logic                                  i_win_ready,
  output logic [CFG_W-1:0]                      o_fill
);

  localparam int WIN_W = DATA_WIDTH * ROW_NUM * COL_NUM;

  logic                          accept;
  logic [CFG_W-1:0]              kw, kh, kw_m1;
  logic [DATA_WIDTH*ROW_NUM-1:0] col_in;
  logic [WIN_W-1:0]              win_q, win_nxt;

  drlp_sld_win_ctrl #(
    .ROW_NUM (ROW_NUM),
    .COL_NUM (COL_NUM),
    .CFG_W   (CFG_W)
  ) u_ctrl (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cfg_load   (i_cfg_load),
    .i_cfg_kw     (i_cfg_kw),
    .i_cfg_kh     (i_cfg_kh),
    .i_cfg_stride (i_cfg_stride),
    .i_col_valid  (i_col_valid),
    .i_win_ready  (i_win_ready),
    .o_col_ready  (o_col_ready),
    .o_accept     (accept),
    .o_win_valid  (o_win_valid),
    .o_fill       (o_fill),
    .o_kw         (kw),
    .o_kh         (kh)
  );

`ifdef DRLP_SLD_WIN_PAD_EN
  assign col_in = i_col_pad ? '0 : i_col_data;
`else
  assign col_in = i_col_data;
`endif

  assign kw_m1 = kw - CFG_W'(1);

  // Newest column lands at kw-1; everything outside the kh x kw kernel stays zero.
  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      localparam int IDX = (r * COL_NUM + c) * DATA_WIDTH;
      logic [DATA_WIDTH-1:0] shift_src;
      if (c < COL_NUM - 1) begin : g_src
        assign shift_src = win_q[IDX+DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_edge
        assign shift_src = '0;
      end
      assign win_nxt[IDX +: DATA_WIDTH] =
        ((CFG_W'(r) >= kh) || (CFG_W'(c) >= kw)) ? '0 :
        (CFG_W'(c) == kw_m1) ? col_in[r*DATA_WIDTH +: DATA_WIDTH] : shift_src;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cfg_load) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= win_nxt;
    end
  end

  assign o_win = win_q;

endmodule
